// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code set 2 constants, FSM state types and move-vector bit indices
package ps2_pkg;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam int MOVE_LEFT  = 3;
    localparam int MOVE_RIGHT = 2;
    localparam int MOVE_UP    = 1;
    localparam int MOVE_DOWN  = 0;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver (sync, clock glitch filter, frame FSM, timeout)
//   clk, rst            system clock, sync active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 lines
//   byte_valid          one-cycle strobe, byte_data holds the good byte
//   err                 one-cycle strobe on bad start/parity/stop or timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0] clk_sync, dat_sync;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] tmo, tmo_d;
    logic [7:0] sh, sh_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic filt, samp, accept, dat, par_ok, par_ok_d, vld_d, err_d;
    rx_state_t state, state_d;
    assign dat = dat_sync[1];
    // the filtered level only flips after FILTER_LEN consecutive differing samples
    assign accept = clk_sync[1] != filt && filt_cnt == FW'(FILTER_LEN - 1);
    always_comb begin
        state_d   = state;
        sh_d      = sh;
        bit_cnt_d = bit_cnt;
        par_ok_d  = par_ok;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (state == RX_IDLE || samp) ? '0 : tmo + 1'b1;
        if (samp) begin
            case (state)
                RX_IDLE: begin
                    err_d     = dat;
                    state_d   = dat ? RX_IDLE : RX_DATA;
                    bit_cnt_d = '0;
                end
                RX_DATA: begin
                    sh_d      = {dat, sh[7:1]};
                    bit_cnt_d = bit_cnt + 1'b1;
                    state_d   = bit_cnt == 3'd7 ? RX_PARITY : RX_DATA;
                end
                RX_PARITY: begin
                    par_ok_d = ^{sh, dat};
                    state_d  = RX_STOP;
                end
                default: begin
                    vld_d   = dat & par_ok;
                    err_d   = ~(dat & par_ok);
                    state_d = RX_IDLE;
                end
            endcase
        end else if (state != RX_IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt       <= 1'b1;
            filt_cnt   <= '0;
            samp       <= 1'b0;
            state      <= RX_IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            par_ok     <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            err        <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            filt_cnt   <= (clk_sync[1] == filt || accept) ? '0 : filt_cnt + 1'b1;
            filt       <= accept ? clk_sync[1] : filt;
            samp       <= accept & ~clk_sync[1];
            state      <= state_d;
            sh         <= sh_d;
            bit_cnt    <= bit_cnt_d;
            par_ok     <= par_ok_d;
            tmo        <= tmo_d;
            byte_valid <= vld_d;
            err        <= err_d;
            byte_data  <= vld_d ? sh : byte_data;
        end
    end
endmodule

// File: rtl/ps2_player_input.sv
// ps2_player_input: PS/2 set-2 make/break decoder driving two players' held-key vectors
//   clk_i, reset_i                 system clock, sync active-high reset
//   ps2_clk_i, ps2_data_i          raw PS/2 lines
//   player_N_move_o                {left, right, up, down}; p1 = WASD, p2 = arrows
//   player_1/2_shoot_o             Space / Enter held
//   scan_valid_o, scan_code_o      good-byte strobe and last good byte
//   frame_error_o                  framing-error / timeout strobe
module ps2_player_input
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_error_o
);
    dec_state_t dec, dec_d;
    logic hit, ext, brk;
    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk       (clk_i),
        .rst       (reset_i),
        .ps2_clk   (ps2_clk_i),
        .ps2_data  (ps2_data_i),
        .byte_valid(scan_valid_o),
        .byte_data (scan_code_o),
        .err       (frame_error_o)
    );
    // hit marks a completed make/break; ext/brk come from the prefix state it completes
    always_comb begin
        dec_d = dec;
        hit   = 1'b0;
        ext   = dec == DEC_EXT || dec == DEC_EXT_BRK;
        brk   = dec == DEC_BRK || dec == DEC_EXT_BRK;
        if (frame_error_o) begin
            dec_d = DEC_BASE;
        end else if (scan_valid_o) begin
            if (brk) begin
                hit   = 1'b1;
                dec_d = DEC_BASE;
            end else if (scan_code_o == SC_EXT) begin
                dec_d = DEC_EXT;
            end else if (scan_code_o == SC_BRK) begin
                dec_d = ext ? DEC_EXT_BRK : DEC_BRK;
            end else begin
                hit   = 1'b1;
                dec_d = DEC_BASE;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dec              <= DEC_BASE;
            player_1_move_o  <= '0;
            player_2_move_o  <= '0;
            player_1_shoot_o <= 1'b0;
            player_2_shoot_o <= 1'b0;
        end else begin
            dec <= dec_d;
            if (hit && ext) begin
                case (scan_code_o)
                    SC_UP:    player_2_move_o[MOVE_UP]    <= ~brk;
                    SC_LEFT:  player_2_move_o[MOVE_LEFT]  <= ~brk;
                    SC_DOWN:  player_2_move_o[MOVE_DOWN]  <= ~brk;
                    SC_RIGHT: player_2_move_o[MOVE_RIGHT] <= ~brk;
                    default: ;
                endcase
            end else if (hit) begin
                case (scan_code_o)
                    SC_W:     player_1_move_o[MOVE_UP]    <= ~brk;
                    SC_A:     player_1_move_o[MOVE_LEFT]  <= ~brk;
                    SC_S:     player_1_move_o[MOVE_DOWN]  <= ~brk;
                    SC_D:     player_1_move_o[MOVE_RIGHT] <= ~brk;
                    SC_SPACE: player_1_shoot_o            <= ~brk;
                    SC_ENTER: player_2_shoot_o            <= ~brk;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_player_input.sv
// tb_ps2_player_input: scoreboard bench for the PS/2 player input decoder
module tb_ps2_player_input;
    import ps2_pkg::*;
    localparam int TMO  = 300;
    localparam int HALF = 20;
    logic clk = 1'b0, reset_i = 1'b1, ps2_clk_i = 1'b1, ps2_data_i = 1'b1;
    logic [3:0] player_1_move_o, player_2_move_o;
    logic player_1_shoot_o, player_2_shoot_o, scan_valid_o, frame_error_o;
    logic [7:0] scan_code_o;
    int compared = 0, mismatched = 0, n_err = 0, both_seen = 0;
    logic [7:0] exp_q[$], obs_q[$];
    ps2_player_input #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .ps2_clk_i       (ps2_clk_i),
        .ps2_data_i      (ps2_data_i),
        .player_1_move_o (player_1_move_o),
        .player_2_move_o (player_2_move_o),
        .player_1_shoot_o(player_1_shoot_o),
        .player_2_shoot_o(player_2_shoot_o),
        .scan_valid_o    (scan_valid_o),
        .scan_code_o     (scan_code_o),
        .frame_error_o   (frame_error_o)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (scan_valid_o) obs_q.push_back(scan_code_o);
            if (frame_error_o) n_err++;
            if (scan_valid_o && frame_error_o) both_seen = 1;
        end
    end
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b ^ bad_par, b, 1'b0};
        if (nbits == 11 && !bad_par) exp_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk_i = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask
    task automatic test_reset;
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if ({player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_keys got %b/%b/%b/%b exp 0", player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o);
        end
        compared++;
        if ({scan_valid_o, scan_code_o, frame_error_o} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_scan got v=%b code=%h err=%b exp 0", scan_valid_o, scan_code_o, frame_error_o);
        end
        reset_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask
    task automatic test_make;
        logic [7:0] e, g;
        fork
            send_frame(SC_W, 1'b0, 11);
            begin
                int n = 0;
                while (!scan_valid_o && n < 2000) begin @(negedge clk); n++; end
                compared++;
                if (!scan_valid_o) begin
                    mismatched++;
                    $display("FAIL make_strobe got no scan_valid_o exp strobe");
                end else begin
                    compared++;
                    if (player_1_move_o !== 4'b0000) begin
                        mismatched++;
                        $display("FAIL make_latency got %b exp 0000 during strobe", player_1_move_o);
                    end
                    @(negedge clk);
                    compared++;
                    if (player_1_move_o !== 4'b0010) begin
                        mismatched++;
                        $display("FAIL make_w got %b exp 0010", player_1_move_o);
                    end
                end
            end
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL make_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_ext;
        logic [7:0] e, g;
        send_frame(SC_EXT, 1'b0, 11);
        send_frame(SC_UP, 1'b0, 11);
        compared++;
        if (player_2_move_o !== 4'b0010) begin
            mismatched++;
            $display("FAIL ext_make got %b exp 0010", player_2_move_o);
        end
        send_frame(SC_EXT, 1'b0, 11);
        send_frame(SC_BRK, 1'b0, 11);
        send_frame(SC_UP, 1'b0, 11);
        compared++;
        if (player_2_move_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL ext_break got %b exp 0000", player_2_move_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL ext_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_parity;
        logic [7:0] e, g;
        int e0 = n_err;
        int o0 = obs_q.size();
        send_frame(SC_SPACE, 1'b1, 11);
        compared++;
        if (n_err - e0 !== 1 || obs_q.size() !== o0 || player_1_shoot_o !== 1'b0) begin
            mismatched++;
            $display("FAIL parity_err got errs=%0d bytes=%0d shoot=%b exp 1/0/0", n_err - e0, obs_q.size() - o0, player_1_shoot_o);
        end
        send_frame(SC_SPACE, 1'b0, 11);
        compared++;
        if (player_1_shoot_o !== 1'b1) begin
            mismatched++;
            $display("FAIL parity_recover got %b exp 1", player_1_shoot_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL parity_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_timeout;
        logic [7:0] e, g;
        int e0 = n_err;
        send_frame(SC_ENTER, 1'b0, 5);
        repeat (TMO + 100) @(negedge clk);
        compared++;
        if (n_err - e0 !== 1) begin
            mismatched++;
            $display("FAIL timeout_err got %0d errors exp 1", n_err - e0);
        end
        send_frame(SC_ENTER, 1'b0, 11);
        compared++;
        if (player_2_shoot_o !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_recover got %b exp 1", player_2_shoot_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL timeout_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_opposing;
        logic [7:0] e, g;
        send_frame(SC_BRK, 1'b0, 11);
        send_frame(SC_W, 1'b0, 11);
        send_frame(SC_A, 1'b0, 11);
        send_frame(SC_D, 1'b0, 11);
        compared++;
        if (player_1_move_o !== 4'b1100) begin
            mismatched++;
            $display("FAIL opposing_hold got %b exp 1100", player_1_move_o);
        end
        send_frame(SC_BRK, 1'b0, 11);
        send_frame(SC_A, 1'b0, 11);
        compared++;
        if (player_1_move_o !== 4'b0100) begin
            mismatched++;
            $display("FAIL opposing_release got %b exp 0100", player_1_move_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL opposing_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_ignored;
        logic [7:0] e, g;
        send_frame(8'hAA, 1'b0, 11);
        send_frame(8'hFA, 1'b0, 11);
        send_frame(SC_UP, 1'b0, 11);
        send_frame(SC_EXT, 1'b0, 11);
        send_frame(SC_W, 1'b0, 11);
        compared++;
        if (player_1_move_o !== 4'b0100 || player_2_move_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL ignored_keys got p1=%b p2=%b exp 0100/0000", player_1_move_o, player_2_move_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL ignored_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_reset_mid;
        logic [7:0] e, g;
        int e0;
        send_frame(SC_W, 1'b0, 11);
        send_frame(SC_S, 1'b0, 6);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o, scan_valid_o, frame_error_o} !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_mid_keys got p1=%b p2=%b s=%b%b v=%b e=%b exp 0", player_1_move_o, player_2_move_o,
                     player_1_shoot_o, player_2_shoot_o, scan_valid_o, frame_error_o);
        end
        reset_i = 1'b0;
        e0 = n_err;
        send_frame(SC_S, 1'b0, 11);
        compared++;
        if (player_1_move_o !== 4'b0001 || n_err !== e0) begin
            mismatched++;
            $display("FAIL reset_mid_s got %b errs=%0d exp 0001 errs=0", player_1_move_o, n_err - e0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx; compared++;
            if (g !== e) begin mismatched++; $display("FAIL reset_mid_code got %h exp %h", g, e); end
        end
    endtask
    task automatic test_final;
        compared++;
        if (obs_q.size() !== 0) begin
            mismatched++;
            $display("FAIL extra_bytes got %0d unexpected bytes exp 0", obs_q.size());
        end
        compared++;
        if (both_seen !== 0) begin
            mismatched++;
            $display("FAIL strobe_overlap got valid and error together exp never");
        end
    endtask
    initial begin
        test_reset;
        test_make;
        test_ext;
        test_parity;
        test_timeout;
        test_opposing;
        test_ignored;
        test_reset_mid;
        test_final;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
